// File: rtl/bit_scan_encoder.sv
// Converts a signed weight to sign-magnitude and emits one shift_sel term per set
// magnitude bit, LSB first, over a valid/ready handshake.
module bit_scan_encoder #(
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = $clog2(W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [W-1:0]     weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] shift_sel,
  output logic             sign,
  output logic             last,
  output logic             zero
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]   state, state_nxt;
  logic [W-1:0] mask, mask_nxt;
  logic         sign_r, sign_nxt;
  logic         zero_r, zero_nxt;

  logic [W-1:0] weight_abs;
  logic         load;
  logic         fire;

  // State register; reset aborts any weight in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mask   <= '0;
      sign_r <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      mask   <= mask_nxt;
      sign_r <= sign_nxt;
      zero_r <= zero_nxt;
    end
  end

  // Next-state and term decode; the most negative weight maps to its own bit pattern.
  always_comb begin
    state_nxt  = state;
    mask_nxt   = mask;
    sign_nxt   = sign_r;
    zero_nxt   = zero_r;
    shift_sel  = '0;
    out_valid  = 1'b0;
    last       = 1'b0;
    sign       = 1'b0;
    zero       = 1'b0;
    weight_abs = weight[W-1] ? W'(~weight + W'(1)) : weight;

    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) shift_sel = SEL_W'(i);
    end

    if (state == SCAN) begin
      out_valid = 1'b1;
      last      = ((mask & (mask - W'(1))) == '0);
      sign      = sign_r;
      zero      = zero_r;
    end

    fire    = out_valid & out_ready;
    w_ready = (state == IDLE) | (fire & last);
    load    = w_valid & w_ready;

    if (fire) begin
      mask_nxt = mask & (mask - W'(1));
      if (last) state_nxt = IDLE;
    end

    if (load) begin
      mask_nxt  = weight_abs;
      sign_nxt  = weight[W-1];
      zero_nxt  = (weight == '0);
      state_nxt = SCAN;
    end
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed and randomized checks of bit_scan_encoder against a term-queue model.
module tb_bit_scan_encoder;

  typedef struct {
    int sel;
    int sgn;
    int zr;
  } term_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       w_valid = 1'b0;
  logic       w_ready;
  logic [7:0] weight = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] shift_sel;
  logic       sign;
  logic       last;
  logic       zero;

  int checks = 0;
  int failures = 0;
  term_t exp_q[$];

  bit_scan_encoder #(.W(8), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
    .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .shift_sel(shift_sel), .sign(sign), .last(last), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected terms of one weight: one per set magnitude bit, LSB first.
  task automatic build(input logic [7:0] w);
    int    a;
    term_t t;
    a = int'($signed(w));
    if (a < 0) a = -a;
    exp_q.delete();
    if (a == 0) begin
      t.sel = 0; t.sgn = 0; t.zr = 1;
      exp_q.push_back(t);
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (((a >> i) & 1) == 1) begin
          t.sel = i; t.sgn = int'(w[7]); t.zr = 0;
          exp_q.push_back(t);
        end
      end
    end
  endtask

  task automatic run_cycle(input logic wv, input logic [7:0] w, input logic ordy, input logic rst);
    bit exp_v, exp_wr;
    @(negedge clk);
    reset = rst; w_valid = wv; weight = w; out_ready = ordy;
    #1;
    if (rst) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_w_ready", int'(w_ready), 1);
      chk("rst_shift_sel", int'(shift_sel), 0);
      chk("rst_sign", int'(sign), 0);
      chk("rst_last", int'(last), 0);
      chk("rst_zero", int'(zero), 0);
      exp_q.delete();
    end else begin
      exp_v  = (exp_q.size() != 0);
      exp_wr = !exp_v || (ordy && exp_q.size() == 1);
      chk("out_valid", int'(out_valid), int'(exp_v));
      chk("w_ready", int'(w_ready), int'(exp_wr));
      if (exp_v) begin
        chk("shift_sel", int'(shift_sel), exp_q[0].sel);
        chk("sign", int'(sign), exp_q[0].sgn);
        chk("last", int'(last), int'(exp_q.size() == 1));
        chk("zero", int'(zero), exp_q[0].zr);
      end
      if (exp_v && ordy) void'(exp_q.pop_front());
      if (wv && exp_wr) build(w);
    end
  endtask

  initial begin
    logic [7:0] rw;
    run_cycle(0, 8'h00, 0, 1);
    // 44 -> 2,3,5
    run_cycle(1, 8'd44, 1, 0);
    repeat (4) run_cycle(0, 8'h00, 1, 0);
    // -3 -> 0,1 negative
    run_cycle(1, 8'hFD, 1, 0);
    repeat (3) run_cycle(0, 8'h00, 1, 0);
    // -128 -> single term at 7
    run_cycle(1, 8'h80, 1, 0);
    repeat (2) run_cycle(0, 8'h00, 1, 0);
    // zero weight -> single null term, then idle
    run_cycle(1, 8'h00, 1, 0);
    repeat (2) run_cycle(0, 8'h00, 1, 0);
    // backpressure on the second term
    run_cycle(1, 8'd44, 1, 0);
    run_cycle(0, 8'h00, 1, 0);
    repeat (3) run_cycle(0, 8'h00, 0, 0);
    repeat (3) run_cycle(0, 8'h00, 1, 0);
    // back-to-back 44 then 5 with w_valid held
    run_cycle(1, 8'd44, 1, 0);
    repeat (3) run_cycle(1, 8'd5, 1, 0);
    repeat (3) run_cycle(0, 8'h00, 1, 0);
    // reset while shift_sel=3 is presented, then weight 1
    run_cycle(1, 8'd44, 1, 0);
    run_cycle(0, 8'h00, 1, 0);
    run_cycle(0, 8'h00, 0, 0);
    run_cycle(0, 8'h00, 0, 1);
    run_cycle(1, 8'd1, 1, 0);
    repeat (2) run_cycle(0, 8'h00, 1, 0);
    // randomized traffic with occasional reset
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 15))
        0:       rw = 8'h00;
        1:       rw = 8'h80;
        2:       rw = 8'hFF;
        default: rw = 8'($urandom);
      endcase
      run_cycle(1'($urandom_range(0, 1)), rw, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 99) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
